// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog_if
//  Description : Control/status bundle of the programmable clock divider.
//                The master side (controller) drives enable and divisor
//                loads. The slave side (divider) returns the divided clock,
//                the edge strobes and the divisor status.
//                With CLKDIV_SYNC_EN defined, a phase-restart input sync_in
//                is added.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
`ifdef CLKDIV_SYNC_EN
    logic             sync_in;
`endif
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;
    logic [CNT_W-1:0] div_active;
    logic             div_pending;

    // Controller side
    modport master (
        output en, div_in, div_load,
`ifdef CLKDIV_SYNC_EN
        output sync_in,
`endif
        input  clk_out, rise_stb, fall_stb, div_active, div_pending
    );

    // Divider side
    modport slave (
        input  en, div_in, div_load,
`ifdef CLKDIV_SYNC_EN
        input  sync_in,
`endif
        output clk_out, rise_stb, fall_stb, div_active, div_pending
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog
//  Description : Runtime-programmable clock divider. Produces a registered,
//                glitch-free divided clock plus single-cycle rise/fall
//                strobes. Divisor changes are applied only at period
//                boundaries (or immediately while disabled). Odd divisors
//                give the extra cycle to the high phase.
//                Optional macro CLKDIV_SYNC_EN adds sync_in, which restarts
//                the period (high phase first) while enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 25,
    parameter bit IDLE_LVL    = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    clk_div_prog_if.slave      bus
);

    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_TWO         = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_DIV_DEFAULT = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             run_q, run_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_div_next;
    logic [CNT_W:0]   w_half;
    logic             w_last;
    logic             w_sync;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = bus.sync_in;
`else
    assign w_sync = 1'b0;
`endif

    // Divisors below 2 cannot form a high and a low phase, so clamp to 2
    assign w_load_val = (bus.div_in < c_TWO) ? c_TWO : bus.div_in;
    assign w_last     = (cnt_q == (div_act_q - c_ONE));

    // Next-state: counter, divisor bookkeeping, clock level and strobes
    always_comb begin
        cnt_d      = cnt_q;
        run_d      = bus.en;
        clk_out_d  = clk_out_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        div_act_d  = div_act_q;
        pend_d     = pend_q;
        pend_val_d = bus.div_load ? w_load_val : pend_val_q;
        w_div_next = div_act_q;
        w_half     = '0;

        if (!bus.en) begin
            // Idle: park at idle level, apply any pending/new divisor at once
            cnt_d     = '0;
            clk_out_d = IDLE_LVL;
            pend_d    = 1'b0;
            if (bus.div_load)
                div_act_d = w_load_val;
            else if (pend_q)
                div_act_d = pend_val_q;
        end else if (!run_q) begin
            // First enabled edge: fresh period, high phase, no strobe
            cnt_d     = '0;
            clk_out_d = 1'b1;
            if (bus.div_load)
                pend_d = 1'b1;
        end else begin
            if (w_sync || w_last) begin
                // Period start: a load in this same cycle wins over the
                // older pending value and applies to the new period
                cnt_d = '0;
                if (bus.div_load) begin
                    w_div_next = w_load_val;
                    pend_d     = 1'b0;
                end else if (pend_q) begin
                    w_div_next = pend_val_q;
                    pend_d     = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + c_ONE;
                if (bus.div_load)
                    pend_d = 1'b1;
            end
            div_act_d = w_div_next;
            w_half    = ({1'b0, w_div_next} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
            clk_out_d = ({1'b0, cnt_d} < w_half);
            rise_d    = clk_out_d & ~clk_out_q;
            fall_d    = ~clk_out_d & clk_out_q;
        end
    end

    // State register with asynchronous reset to idle and default divisor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            run_q      <= 1'b0;
            clk_out_q  <= IDLE_LVL;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            div_act_q  <= c_DIV_DEFAULT;
            pend_q     <= 1'b0;
            pend_val_q <= c_DIV_DEFAULT;
        end else begin
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            clk_out_q  <= clk_out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            div_act_q  <= div_act_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
        end
    end

    assign bus.clk_out     = clk_out_q;
    assign bus.rise_stb    = rise_q;
    assign bus.fall_stb    = fall_q;
    assign bus.div_active  = div_act_q;
    assign bus.div_pending = pend_q;

endmodule
`default_nettype wire
